// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

    localparam int DATA_W  = 8;
    localparam int PRESC_W = 6;

    // bit_cnt value of the last data bit (data bits occupy 1..DATA_W)
    localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_W);

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and bit counter for the UART receiver.
// edge_cnt runs 0..prescale-1 while enabled; bit_end marks the last edge
// of a bit, where edge_cnt wraps and bit_cnt advances.
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               enable,
    input  logic               clear,
    input  logic [PRESC_W-1:0] prescale,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [3:0]         bit_cnt,
    output logic               bit_end
);

    localparam logic [PRESC_W-1:0] PRESC_ONE = 1;

    logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;

    assign bit_end  = enable && (edge_cnt_q == (prescale - PRESC_ONE));
    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;

    // Next counter values: clear wins, otherwise count edges and wrap at bit end
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (clear) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (enable) begin
            if (bit_end) begin
                edge_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + 4'd1;
            end else begin
                edge_cnt_d = edge_cnt_q + PRESC_ONE;
            end
        end
    end

    // Counter registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: detects the start bit, times each bit via
// the edge/bit counters, strobes the deserializer once per data bit and
// checks parity and stop bits. Frame settings are latched at start detection.
module uart_rx_fsm
    import uart_rx_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic               Sampled_Bit,
    output logic               Sampler_Enable,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [3:0]         bit_cnt,
    output logic               Deserializer_Enable,
    output logic               Data_Valid,
    output logic               Parity_Error,
    output logic               Stop_Error
);

    rx_state_e          state_q, state_d;
    logic [PRESC_W-1:0] prescale_q, prescale_d;
    logic               par_en_q, par_en_d;
    logic               par_typ_q, par_typ_d;
    logic               parity_acc_q, parity_acc_d;
    logic               par_err_q, par_err_d;
    logic               stop_err_q, stop_err_d;
    logic               data_valid_q, data_valid_d;
    logic               deser_en;
    logic               bit_end;
    logic               expected_par;

    // Counters run outside IDLE and are zeroed whenever the FSM is (re)entering IDLE
    uart_rx_edge_bit_cnt u_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .enable   (state_q != IDLE),
        .clear    (state_d == IDLE),
        .prescale (prescale_q),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_end  (bit_end)
    );

    assign expected_par        = (par_typ_q == PAR_ODD) ? ~parity_acc_q : parity_acc_q;
    assign Sampler_Enable      = (state_q != IDLE);
    assign Deserializer_Enable = deser_en;
    assign Data_Valid          = data_valid_q;
    assign Parity_Error        = par_err_q;
    assign Stop_Error          = stop_err_q;

    // Next-state, frame checks and deserializer strobe
    always_comb begin
        state_d      = state_q;
        prescale_d   = prescale_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        parity_acc_d = parity_acc_q;
        par_err_d    = par_err_q;
        stop_err_d   = stop_err_q;
        data_valid_d = 1'b0;
        deser_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d      = START;
                    prescale_d   = Prescale;
                    par_en_d     = PAR_EN;
                    par_typ_d    = PAR_TYP;
                    parity_acc_d = 1'b0;
                    par_err_d    = 1'b0;
                    stop_err_d   = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = Sampled_Bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    deser_en     = 1'b1;
                    parity_acc_d = parity_acc_q ^ Sampled_Bit;
                    if (bit_cnt == LAST_DATA_BIT) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    if (Sampled_Bit != expected_par) begin
                        par_err_d = 1'b1;
                    end
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!Sampled_Bit) begin
                        stop_err_d = 1'b1;
                    end
                    data_valid_d = Sampled_Bit && !par_err_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched frame settings and registered status
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            prescale_q   <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            parity_acc_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prescale_q   <= prescale_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            parity_acc_q <= parity_acc_d;
            par_err_q    <= par_err_d;
            stop_err_q   <= stop_err_d;
            data_valid_q <= data_valid_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: table of single frames plus
// hand-written glitch, back-to-back and mid-frame reset sequences.
module tb_uart_rx_fsm;
    import uart_rx_pkg::*;

    logic               CLK = 1'b0;
    logic               RST;
    logic               RX_IN;
    logic [PRESC_W-1:0] Prescale;
    logic               PAR_EN;
    logic               PAR_TYP;
    logic               Sampled_Bit;
    logic               Sampler_Enable;
    logic [PRESC_W-1:0] edge_cnt;
    logic [3:0]         bit_cnt;
    logic               Deserializer_Enable;
    logic               Data_Valid;
    logic               Parity_Error;
    logic               Stop_Error;

    uart_rx_fsm dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .RX_IN               (RX_IN),
        .Prescale            (Prescale),
        .PAR_EN              (PAR_EN),
        .PAR_TYP             (PAR_TYP),
        .Sampled_Bit         (Sampled_Bit),
        .Sampler_Enable      (Sampler_Enable),
        .edge_cnt            (edge_cnt),
        .bit_cnt             (bit_cnt),
        .Deserializer_Enable (Deserializer_Enable),
        .Data_Valid          (Data_Valid),
        .Parity_Error        (Parity_Error),
        .Stop_Error          (Stop_Error)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [PRESC_W-1:0] prescale;
        logic               par_en;
        logic               par_typ;
        logic [7:0]         data;
        logic               par_bit;
        logic               stop_bit;
        int                 exp_strobes;
        logic               exp_dv;
        logic               exp_perr;
        logic               exp_serr;
        int                 exp_len;
    } vec_t;

    vec_t vecs[6];

    int checks = 0;
    int errors = 0;

    // Monitor-owned counters and deserializer model
    int         cyc = 0;
    int         des_total = 0;
    int         dv_total = 0;
    int         se_total = 0;
    logic [7:0] shreg = 8'h00;
    logic [7:0] dv_data[16];
    int         dv_cyc[16];

    // Test-owned snapshots
    int base_des;
    int base_dv;
    int base_se;

    // Line model: sampler output is the line delayed by three cycles
    logic [3:0] hist;

    // Observe outputs mid-cycle; emulate the downstream LSB-first deserializer
    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (Sampler_Enable) se_total = se_total + 1;
        if (Deserializer_Enable) begin
            des_total = des_total + 1;
            shreg = {Sampled_Bit, shreg[7:1]};
        end
        if (Data_Valid) begin
            if (dv_total < 16) begin
                dv_data[dv_total] = shreg;
                dv_cyc[dv_total]  = cyc;
            end
            dv_total = dv_total + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input logic line);
        @(posedge CLK);
        #2;
        hist        = {hist[2:0], line};
        RX_IN       = line;
        Sampled_Bit = hist[3];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1);
    endtask

    task automatic snapshot();
        base_des = des_total;
        base_dv  = dv_total;
        base_se  = se_total;
    endtask

    // Send one frame; optionally disturb the frame settings after start detection
    task automatic sendFrame(input logic [7:0] data, input int p, input logic pe,
                             input logic pbit, input logic sbit, input logic scramble);
        logic [10:0] bits;
        int          nbits;
        bits       = '1;
        bits[0]    = 1'b0;
        bits[8:1]  = data;
        if (pe) begin
            bits[9]  = pbit;
            bits[10] = sbit;
            nbits    = 11;
        end else begin
            bits[9]  = sbit;
            nbits    = 10;
        end
        for (int b = 0; b < nbits; b++) begin
            for (int k = 0; k < p; k++) begin
                tick(bits[b]);
                if (b == 0 && k == 1 && scramble) begin
                    Prescale = (p == 8) ? 6'd16 : 6'd8;
                    PAR_EN   = ~pe;
                    PAR_TYP  = ~PAR_TYP;
                end
                if (b == 0 && k == p / 2) begin
                    checkOutput("flags_cleared_on_start", {30'd0, Parity_Error, Stop_Error}, 32'd0);
                end
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        snapshot();
        Prescale = v.prescale;
        PAR_EN   = v.par_en;
        PAR_TYP  = v.par_typ;
        sendFrame(v.data, int'(v.prescale), v.par_en, v.par_bit, v.stop_bit, 1'b1);
        idle(8);
        checkOutput($sformatf("v%0d_strobes", idx), des_total - base_des, v.exp_strobes);
        checkOutput($sformatf("v%0d_data_valid_count", idx), dv_total - base_dv, {31'd0, v.exp_dv});
        checkOutput($sformatf("v%0d_deser_data", idx), {24'd0, shreg}, {24'd0, v.data});
        if (v.exp_dv) begin
            checkOutput($sformatf("v%0d_dv_data", idx), {24'd0, dv_data[base_dv]}, {24'd0, v.data});
        end
        checkOutput($sformatf("v%0d_parity_error", idx), {31'd0, Parity_Error}, {31'd0, v.exp_perr});
        checkOutput($sformatf("v%0d_stop_error", idx), {31'd0, Stop_Error}, {31'd0, v.exp_serr});
        checkOutput($sformatf("v%0d_frame_len", idx), se_total - base_se, v.exp_len);
    endtask

    function automatic logic [31:0] allOutputs();
        return {17'd0, Sampler_Enable, edge_cnt, bit_cnt, Deserializer_Enable,
                Data_Valid, Parity_Error, Stop_Error};
    endfunction

    initial begin
        logic [10:0] bits;
        int          diff;

        vecs[0] = '{prescale: 6'd8,  par_en: 1'b1, par_typ: 1'b0, data: 8'hA5, par_bit: 1'b0, stop_bit: 1'b1,
                    exp_strobes: 8, exp_dv: 1'b1, exp_perr: 1'b0, exp_serr: 1'b0, exp_len: 88};
        vecs[1] = '{prescale: 6'd16, par_en: 1'b1, par_typ: 1'b1, data: 8'h3C, par_bit: 1'b0, stop_bit: 1'b1,
                    exp_strobes: 8, exp_dv: 1'b0, exp_perr: 1'b1, exp_serr: 1'b0, exp_len: 176};
        vecs[2] = '{prescale: 6'd16, par_en: 1'b0, par_typ: 1'b0, data: 8'hFF, par_bit: 1'b0, stop_bit: 1'b0,
                    exp_strobes: 8, exp_dv: 1'b0, exp_perr: 1'b0, exp_serr: 1'b1, exp_len: 160};
        vecs[3] = '{prescale: 6'd8,  par_en: 1'b0, par_typ: 1'b0, data: 8'h00, par_bit: 1'b0, stop_bit: 1'b1,
                    exp_strobes: 8, exp_dv: 1'b1, exp_perr: 1'b0, exp_serr: 1'b0, exp_len: 80};
        vecs[4] = '{prescale: 6'd32, par_en: 1'b1, par_typ: 1'b1, data: 8'h01, par_bit: 1'b0, stop_bit: 1'b1,
                    exp_strobes: 8, exp_dv: 1'b1, exp_perr: 1'b0, exp_serr: 1'b0, exp_len: 352};
        vecs[5] = '{prescale: 6'd8,  par_en: 1'b1, par_typ: 1'b0, data: 8'h07, par_bit: 1'b0, stop_bit: 1'b1,
                    exp_strobes: 8, exp_dv: 1'b0, exp_perr: 1'b1, exp_serr: 1'b0, exp_len: 88};

        RST         = 1'b0;
        RX_IN       = 1'b1;
        Sampled_Bit = 1'b1;
        Prescale    = 6'd8;
        PAR_EN      = 1'b0;
        PAR_TYP     = 1'b0;
        hist        = 4'b1111;

        @(posedge CLK);
        #1;
        checkOutput("reset_outputs", allOutputs(), 32'd0);
        repeat (2) @(posedge CLK);
        #2;
        RST = 1'b1;
        idle(4);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Start glitch: three low cycles, sampler sees high at the start bit end
        $display("[TB] start-bit glitch");
        snapshot();
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0);
        idle(14);
        checkOutput("glitch_start_len", se_total - base_se, 32'd8);
        checkOutput("glitch_strobes", des_total - base_des, 32'd0);
        checkOutput("glitch_data_valid", dv_total - base_dv, 32'd0);
        checkOutput("glitch_flags", {30'd0, Parity_Error, Stop_Error}, 32'd0);
        checkOutput("glitch_back_idle", {31'd0, Sampler_Enable}, 32'd0);

        // Back-to-back frames with no idle gap
        $display("[TB] back-to-back frames");
        snapshot();
        Prescale = 6'd32;
        PAR_EN   = 1'b0;
        sendFrame(8'h01, 32, 1'b0, 1'b0, 1'b1, 1'b0);
        sendFrame(8'h80, 32, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(8);
        checkOutput("b2b_dv_count", dv_total - base_dv, 32'd2);
        checkOutput("b2b_strobes", des_total - base_des, 32'd16);
        checkOutput("b2b_first_data", {24'd0, dv_data[base_dv]}, 32'h01);
        checkOutput("b2b_second_data", {24'd0, dv_data[base_dv + 1]}, 32'h80);
        diff = dv_cyc[base_dv + 1] - dv_cyc[base_dv];
        checkOutput("b2b_dv_spacing_320pm1", {31'd0, (diff >= 319 && diff <= 321)}, 32'd1);

        // Reset during data bit 4, then a clean frame
        $display("[TB] reset mid-frame");
        snapshot();
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        bits     = {2'b11, 8'h33, 1'b0};
        for (int t = 0; t < 36; t++) tick(bits[t / 8]);
        checkOutput("pre_reset_bit_cnt", {28'd0, bit_cnt}, 32'd4);
        RST = 1'b0;
        #1;
        checkOutput("mid_reset_outputs", allOutputs(), 32'd0);
        idle(3);
        RST = 1'b1;
        idle(4);
        checkOutput("mid_reset_no_dv", dv_total - base_dv, 32'd0);
        checkOutput("mid_reset_strobes", des_total - base_des, 32'd3);
        snapshot();
        sendFrame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(8);
        checkOutput("post_reset_dv_count", dv_total - base_dv, 32'd1);
        checkOutput("post_reset_data", {24'd0, dv_data[base_dv]}, 32'h5A);
        checkOutput("post_reset_flags", {30'd0, Parity_Error, Stop_Error}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
